// File: rtl/ps2_pkg.sv
// Shared types, protocol constants and the set-2 to HID usage map for the PS/2 keyboard path.
package ps2_pkg;

  typedef enum logic {R_IDLE, R_SHIFT} rx_state_t;
  typedef enum logic [1:0] {D_IDLE, D_BREAK, D_EXT, D_EXT_BREAK} dec_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_E     = 8'h08;
  localparam logic [7:0] HID_Q     = 8'h14;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_X     = 8'h1B;
  localparam logic [7:0] HID_Z     = 8'h1D;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_UP    = 8'h52;

  function automatic logic [7:0] set2_to_hid(input logic ext, input logic [7:0] code);
    logic [7:0] hid;
    hid = HID_NONE;
    if (ext) begin
      case (code)
        8'h75:   hid = HID_UP;
        8'h72:   hid = HID_DOWN;
        8'h6B:   hid = HID_LEFT;
        8'h74:   hid = HID_RIGHT;
        default: hid = HID_NONE;
      endcase
    end else begin
      case (code)
        8'h1D:   hid = HID_W;
        8'h1B:   hid = HID_S;
        8'h1C:   hid = HID_A;
        8'h23:   hid = HID_D;
        8'h15:   hid = HID_Q;
        8'h24:   hid = HID_E;
        8'h1A:   hid = HID_Z;
        8'h22:   hid = HID_X;
        default: hid = HID_NONE;
      endcase
    end
    return hid;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, glitch filters, 11-bit frame FSM with parity/stop
// checking and an inter-edge timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_byte,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0] raw;
  logic [1:0] level;
  assign raw = {ps2_data, ps2_clk};

  // Lane 0 is the PS/2 clock, lane 1 the data; both idle high after reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic          s1_reg, s2_reg, lvl_reg;
    logic [FW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_reg  <= 1'b0;
        s2_reg  <= 1'b0;
        lvl_reg <= 1'b1;
        cnt_reg <= '0;
      end else begin
        s1_reg <= raw[gi];
        s2_reg <= s1_reg;
        if (s2_reg == lvl_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == FW'(FILTER_LEN - 1)) begin
          lvl_reg <= s2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign level[gi] = lvl_reg;
  end

  logic          clk_prev_reg;
  logic          fall;
  logic          data_level;
  rx_state_t     state_reg, state_next;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] timer_reg;
  logic          timeout;
  logic          valid_next, err_next;

  assign data_level = level[1];
  assign fall       = clk_prev_reg & ~level[0];
  assign timeout    = (state_reg == R_SHIFT) && !fall && (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= R_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      R_IDLE:  if (fall && !data_level) state_next = R_SHIFT;
      R_SHIFT: if (timeout || (fall && bit_cnt_reg == 4'd9)) state_next = R_IDLE;
      default: state_next = R_IDLE;
    endcase
  end

  always_comb begin
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      R_IDLE: err_next = fall && data_level;
      R_SHIFT: begin
        if (timeout) begin
          err_next = 1'b1;
        end else if (fall && bit_cnt_reg == 4'd9) begin
          // Odd parity over data+parity, and the stop bit must be high.
          if ((^shift_reg ^ parity_reg) && data_level) valid_next = 1'b1;
          else                                         err_next   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_reg <= 1'b1;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      timer_reg    <= '0;
      scan_byte    <= '0;
      scan_valid   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      clk_prev_reg <= level[0];
      scan_valid   <= valid_next;
      frame_err    <= err_next;
      if (valid_next) scan_byte <= shift_reg;
      if (state_reg == R_IDLE) begin
        bit_cnt_reg <= '0;
        timer_reg   <= '0;
      end else if (fall) begin
        timer_reg   <= '0;
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
        if (bit_cnt_reg < 4'd8)  shift_reg  <= {data_level, shift_reg[7:1]};
        if (bit_cnt_reg == 4'd8) parity_reg <= data_level;
      end else begin
        timer_reg <= timer_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard front end: receives set-2 bytes and holds the HID usage of the pressed mapped key.
module ps2_keycode
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic [7:0] scan_byte,
  output logic       scan_valid,
  output logic       frame_err
);

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_byte (scan_byte),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  dec_state_t dec_reg, dec_next;
  logic [7:0] keycode_reg, keycode_next;
  logic [7:0] hid;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dec_reg     <= D_IDLE;
      keycode_reg <= '0;
    end else begin
      dec_reg     <= dec_next;
      keycode_reg <= keycode_next;
    end
  end

  always_comb begin
    dec_next = dec_reg;
    if (frame_err) begin
      dec_next = D_IDLE;
    end else if (scan_valid) begin
      case (dec_reg)
        D_IDLE: begin
          if (scan_byte == PS2_EXT)        dec_next = D_EXT;
          else if (scan_byte == PS2_BREAK) dec_next = D_BREAK;
          else                             dec_next = D_IDLE;
        end
        D_EXT:   dec_next = (scan_byte == PS2_BREAK) ? D_EXT_BREAK : D_IDLE;
        default: dec_next = D_IDLE;
      endcase
    end
  end

  assign hid = set2_to_hid((dec_reg == D_EXT) || (dec_reg == D_EXT_BREAK), scan_byte);

  // Makes override whatever is held; a break only clears the key that is actually held.
  always_comb begin
    keycode_next = keycode_reg;
    if (scan_valid && !frame_err) begin
      case (dec_reg)
        D_IDLE:
          if (scan_byte != PS2_EXT && scan_byte != PS2_BREAK && hid != HID_NONE) keycode_next = hid;
        D_EXT:
          if (scan_byte != PS2_BREAK && hid != HID_NONE) keycode_next = hid;
        default:
          if (hid == keycode_reg) keycode_next = HID_NONE;
      endcase
    end
  end

  assign keycode = keycode_reg;

endmodule

// File: tb/tb_ps2_keycode.sv
// Scoreboard bench for ps2_keycode: randomized and directed PS/2 frames against a keyboard-level model.
module tb_ps2_keycode;

  localparam int H = 20;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode, scan_byte;
  logic       scan_valid, frame_err;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic [7:0] kc;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] m_kc = 8'h00;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  logic [7:0] map_code[12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h15, 8'h24, 8'h1A, 8'h22,
                               8'h75, 8'h72, 8'h6B, 8'h74};
  bit         map_ext[12]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  logic [7:0] map_hid[12]  = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h14, 8'h08, 8'h1D, 8'h1B,
                               8'h52, 8'h51, 8'h50, 8'h4F};
  logic [7:0] pool[17]     = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h15, 8'h24, 8'h1A, 8'h22,
                               8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hFA};

  always #5 Clk = ~Clk;

  ps2_keycode #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .scan_byte (scan_byte),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ref_hid(input bit ext, input logic [7:0] c);
    for (int i = 0; i < 12; i++)
      if (map_ext[i] == ext && map_code[i] == c) return map_hid[i];
    return 8'h00;
  endfunction

  // Keyboard-level model: a pending E0 prefix and a pending F0 prefix qualify the next byte.
  function automatic void model_byte(input logic [7:0] b, input bit err);
    exp_t e;
    logic [7:0] h;
    if (err) begin
      m_ext = 0;
      m_brk = 0;
    end else if (m_brk) begin
      h = ref_hid(m_ext, b);
      if (h == m_kc) m_kc = 8'h00;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0 && !m_ext) begin
      m_ext = 1;
    end else begin
      h = ref_hid(m_ext, b);
      if (h != 8'h00) m_kc = h;
      m_ext = 0;
    end
    e.is_err = err;
    e.data   = b;
    e.kc     = m_kc;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive_bits(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_bit);
    logic [10:0] f;
    f = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (i == glitch_bit) begin
        cyc(H / 2);
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(H / 2 - 3);
      end else begin
        cyc(H);
      end
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    cyc(H);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_bit);
    model_byte(b, bad_par);
    drive_bits(b, bad_par, 11, glitch_bit);
    ps2_data = 1'b1;
    cyc(2 * H);
  endtask

  // Monitor: pops one expectation per received byte or error and checks keycode a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n && (scan_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got valid=%0b err=%0b byte=%02h expected none",
                   scan_valid, frame_err, scan_byte);
        end else begin
          e = exp_q.pop_front();
          check("event_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
          check("event_is_valid", {31'd0, scan_valid}, {31'd0, !e.is_err});
          if (!e.is_err) check("scan_byte", {24'd0, scan_byte}, {24'd0, e.data});
          @(negedge Clk);
          check("keycode", {24'd0, keycode}, {24'd0, e.kc});
          $display("rx byte=%02h err=%0b keycode=%02h expected_keycode=%02h",
                   e.data, e.is_err, keycode, e.kc);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish before 5ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    exp_t e;
    logic [7:0] b;

    cyc(5);
    check("reset_keycode", {24'd0, keycode}, 32'h0);
    check("reset_scan_byte", {24'd0, scan_byte}, 32'h0);
    check("reset_scan_valid", {31'd0, scan_valid}, 32'h0);
    check("reset_frame_err", {31'd0, frame_err}, 32'h0);
    Reset_n = 1'b1;
    cyc(30);

    send_frame(8'h1D, 0, -1);
    send_frame(8'hF0, 0, -1);
    send_frame(8'h1D, 0, -1);
    send_frame(8'hE0, 0, -1);
    send_frame(8'h75, 0, -1);
    send_frame(8'hE0, 0, -1);
    send_frame(8'hF0, 0, -1);
    send_frame(8'h75, 0, -1);
    send_frame(8'h1C, 0, -1);
    send_frame(8'hF0, 0, -1);
    send_frame(8'h1B, 0, -1);
    send_frame(8'h23, 1, -1);
    send_frame(8'h24, 0, -1);

    // Abandoned frame: start plus five data bits, then silence until the timeout fires.
    model_byte(8'h3C, 1);
    drive_bits(8'h3C, 0, 6, -1);
    ps2_data = 1'b1;
    n = 0;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge Clk);
      n++;
      if (frame_err) seen = 1;
    end
    check("timeout_seen", {31'd0, seen}, 32'h1);
    check("timeout_window", {31'd0, (n >= 60 && n <= 85)}, 32'h1);
    cyc(2 * H);
    send_frame(8'h1A, 0, -1);

    send_frame(8'h22, 0, 3);

    // Reset in the middle of bit 4 of a frame for 0x15.
    drive_bits(8'h15, 0, 4, -1);
    ps2_data = 1'b1;
    cyc(5);
    Reset_n = 1'b0;
    #1;
    check("midreset_keycode", {24'd0, keycode}, 32'h0);
    check("midreset_scan_byte", {24'd0, scan_byte}, 32'h0);
    check("midreset_scan_valid", {31'd0, scan_valid}, 32'h0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'h0);
    cyc(3);
    Reset_n = 1'b1;
    m_kc = 8'h00;
    m_ext = 0;
    m_brk = 0;
    cyc(30);
    send_frame(8'h15, 0, -1);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 16)];
      send_frame(b, ($urandom_range(0, 7) == 0), -1);
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge Clk);
    check("queue_drained", exp_q.size(), 32'h0);
    cyc(5);
    @(negedge Clk);
    check("final_keycode", {24'd0, keycode}, {24'd0, m_kc});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
